div_sqrt_arbiter: RTL

Shares one `DivSqrtRecFN_small` unit (single-precision recoded, one operation in flight) among `NUM_REQ` requesters. Requests are granted round-robin, and the winner's operands go to the unit. The single-cycle result pulse is captured into a response register. The response is returned to the owning requester through a valid/ready handshake. The block sits between the FPU issue ports and the divide/sqrt unit, and owns all sequencing of that unit.

---
 rtl/div_sqrt_arb_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/div_sqrt_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_sqrt_arb_pkg.sv
// Shared types and widths for the divide/sqrt arbiter.
package div_sqrt_arb_pkg;

    localparam int unsigned REC_W  = 33;
    localparam int unsigned RM_W   = 3;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Operation presented to the divide/sqrt unit.
    typedef struct packed {
        logic              sqrt_op;
        logic [REC_W-1:0]  a;
        logic [REC_W-1:0]  b;
        logic [RM_W-1:0]   rm;
    } fu_req_t;

    // Result held for the owning requester.
    typedef struct packed {
        logic [REC_W-1:0]  res;
        logic [FLAG_W-1:0] flags;
        logic              is_sqrt;
    } fu_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    // Search from the pointer upward; idx_o stays 0 when nothing is requesting.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        cand  = '0;
        gnt_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (en_i && found) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/div_sqrt_arbiter.sv
// Shares one recoded single-precision divide/sqrt unit among NUM_REQ requesters.
module div_sqrt_arbiter
    import div_sqrt_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_sqrtOp,
    input  logic [NUM_REQ*REC_W-1:0] req_a,
    input  logic [NUM_REQ*REC_W-1:0] req_b,
    input  logic [NUM_REQ*RM_W-1:0]  req_roundingMode,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [REC_W-1:0]         resp_out,
    output logic [FLAG_W-1:0]        resp_exceptionFlags,
    output logic                     resp_isSqrt,
    input  logic                     fu_inReady,
    output logic                     fu_inValid,
    output logic                     fu_sqrtOp,
    output logic [REC_W-1:0]         fu_a,
    output logic [REC_W-1:0]         fu_b,
    output logic [RM_W-1:0]          fu_roundingMode,
    input  logic                     fu_outValid_div,
    input  logic                     fu_outValid_sqrt,
    input  logic [REC_W-1:0]         fu_out,
    input  logic [FLAG_W-1:0]        fu_exceptionFlags,
    output logic                     busy,
    output logic                     err_spurious,
    output logic [CNT_W-1:0]         op_count
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      tag_q, tag_d;
    fu_resp_t           resp_q, resp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               arb_en;
    logic               any_req;
    logic               issue;
    logic               fu_pulse;
    fu_req_t            fu_req;

    assign any_req  = |req_valid;
    assign fu_pulse = fu_outValid_div | fu_outValid_sqrt;
    assign arb_en   = (state_q == IDLE) && fu_inReady;
    assign issue    = (state_q == IDLE) && any_req && fu_inReady;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Operand mux: follows the picked requester (requester 0 when none is valid).
    always_comb begin
        fu_req = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                fu_req.sqrt_op = req_sqrtOp[i];
                fu_req.a       = req_a[i*REC_W +: REC_W];
                fu_req.b       = req_b[i*REC_W +: REC_W];
                fu_req.rm      = req_roundingMode[i*RM_W +: RM_W];
            end
        end
    end

    assign fu_sqrtOp       = fu_req.sqrt_op;
    assign fu_a            = fu_req.a;
    assign fu_b            = fu_req.b;
    assign fu_roundingMode = fu_req.rm;

    // State register; async clear drops any in-flight or held result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: issue, wait for the unit pulse, then hold until the owner accepts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue)              state_d = BUSY;
            BUSY:    if (fu_pulse)           state_d = RESP;
            RESP:    if (resp_ready[tag_q])  state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Output/datapath decode: handshakes, pointer advance, result capture, error flag.
    always_comb begin
        req_ready  = '0;
        fu_inValid = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        tag_d      = tag_q;
        resp_d     = resp_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                req_ready  = gnt;
                fu_inValid = issue;
                if (issue) begin
                    tag_d    = gnt_idx;
                    rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
                end
                if (fu_pulse) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (fu_pulse) begin
                    resp_d.res     = fu_out;
                    resp_d.flags   = fu_exceptionFlags;
                    resp_d.is_sqrt = fu_outValid_sqrt;
                    cnt_d          = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (fu_pulse) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                err_d = err_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            tag_q    <= '0;
            resp_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
            resp_q   <= resp_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // One-hot response valid toward the owning requester.
    always_comb begin
        resp_valid = '0;
        if (state_q == RESP) begin
            resp_valid[tag_q] = 1'b1;
        end
    end

    assign resp_out            = resp_q.res;
    assign resp_exceptionFlags = resp_q.flags;
    assign resp_isSqrt         = resp_q.is_sqrt;
    assign busy                = (state_q != IDLE);
    assign err_spurious        = err_q;
    assign op_count            = cnt_q;

endmodule
